// File: rtl/usb_host_pkg.sv
// usb_host_pkg: shared line-state codes, FSM states and limits
// for the full-speed USB host transmitter.
package usb_host_pkg;

  // {D+, D-}
  typedef logic [1:0] line_t;

  localparam line_t LS_J   = 2'b10;
  localparam line_t LS_K   = 2'b01;
  localparam line_t LS_SE0 = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP
  } tx_state_e;

  localparam int unsigned USB_STUFF_LIMIT = 6;

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// usb_nrzi_stuffer: ones counter, stuff-bit insertion and NRZI level.
// level_o is the level the current shifted bit produces (1 = J).
module usb_nrzi_stuffer
  import usb_host_pkg::*;
(
  input  logic clk48_host,
  input  logic reset,
  input  logic start,
  input  logic shift,
  input  logic bit_i,
  output logic stall,
  output logic level_o
);

  logic       level_q, level_d;
  logic [2:0] ones_q, ones_d;
  logic       prev_lvl;
  logic [2:0] prev_ones;
  logic       line_bit;

  always_comb begin
    prev_lvl  = start ? 1'b1 : level_q;
    prev_ones = start ? 3'd0 : ones_q;
    stall     = (ones_q == 3'(USB_STUFF_LIMIT));
    // a stuff bit is a forced zero, i.e. a toggle
    line_bit  = bit_i & ~(stall & ~start);
    level_o   = line_bit ? prev_lvl : ~prev_lvl;
    level_d   = level_q;
    ones_d    = ones_q;
    if (shift) begin
      level_d = level_o;
      ones_d  = line_bit ? prev_ones + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk48_host) begin
    if (reset) begin
      level_q <= 1'b1;
      ones_q  <= '0;
    end else begin
      level_q <= level_d;
      ones_q  <= ones_d;
    end
  end

endmodule

// File: rtl/usb_host_tx.sv
// usb_host_tx: full-speed USB host packet serialiser.
// SYNC, LSB-first NRZI with bit stuffing, EOP; one line bit per CLK_DIV clocks.
module usb_host_tx
  import usb_host_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'h80
) (
  input  logic       clk48_host,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       usb_d_p_o,
  output logic       usb_d_n_o,
  output logic       usb_oe,
  output logic       busy,
  output logic       tx_underflow
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sreg_q, sreg_d;
  logic          last_q, last_d;
  logic [2:0]    idx_q, idx_d;
  line_t         line_q, line_d, line_nx;
  logic          oe_q, oe_d;
  logic          unf_q, unf_d;
  logic          use_lvl, strobe, ready;
  logic          st_start, st_shift, st_bit;
  logic          st_stall, st_level;

  // last cycle of the line bit currently on the wire
  assign strobe = (cnt_q == CW'(CLK_DIV - 1));

  usb_nrzi_stuffer u_stuff (
    .clk48_host (clk48_host),
    .reset      (reset),
    .start      (st_start),
    .shift      (st_shift),
    .bit_i      (st_bit),
    .stall      (st_stall),
    .level_o    (st_level)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    sreg_d   = sreg_q;
    last_d   = last_q;
    idx_d    = idx_q;
    line_d   = line_q;
    oe_d     = oe_q;
    unf_d    = 1'b0;
    use_lvl  = 1'b0;
    st_start = 1'b0;
    st_shift = 1'b0;
    st_bit   = 1'b0;
    ready    = 1'b0;
    if (state_q != ST_IDLE && !strobe) cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (tx_valid) begin
          state_d  = ST_SYNC;
          sreg_d   = tx_data;
          last_d   = tx_last;
          idx_d    = '0;
          st_start = 1'b1;
          st_shift = 1'b1;
          st_bit   = SYNC_BYTE[0];
          use_lvl  = 1'b1;
          oe_d     = 1'b1;
        end
      end
      ST_SYNC, ST_DATA: if (strobe) begin
        st_shift = 1'b1;
        use_lvl  = 1'b1;
        if (st_stall) begin
          st_bit = 1'b0;
        end else if (idx_q != 3'd7) begin
          st_bit = (state_q == ST_SYNC) ? SYNC_BYTE[idx_q + 3'd1]
                                        : sreg_q[idx_q + 3'd1];
          idx_d  = idx_q + 3'd1;
        end else if (state_q == ST_SYNC) begin
          st_bit  = sreg_q[0];
          idx_d   = '0;
          state_d = ST_DATA;
        end else begin
          ready = ~last_q;
          if (ready && tx_valid) begin
            st_bit = tx_data[0];
            sreg_d = tx_data;
            last_d = tx_last;
            idx_d  = '0;
          end else begin
            st_shift = 1'b0;
            use_lvl  = 1'b0;
            line_d   = LS_SE0;
            idx_d    = '0;
            state_d  = ST_EOP;
            unf_d    = ~last_q;
          end
        end
      end
      ST_EOP: if (strobe) begin
        idx_d = idx_q + 3'd1;
        unique case (1'b1)
          idx_q == 3'd0: line_d = LS_SE0;
          idx_q == 3'd1: line_d = LS_J;
          default: begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            line_d  = LS_J;
            idx_d   = '0;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign line_nx  = use_lvl ? (st_level ? LS_J : LS_K) : line_d;
  assign tx_ready = ready & ~reset;

  always_ff @(posedge clk48_host) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      line_q  <= LS_J;
      oe_q    <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      line_q  <= line_nx;
      oe_q    <= oe_d;
      unf_q   <= unf_d;
    end
  end

  assign usb_d_p_o    = line_q[1];
  assign usb_d_n_o    = line_q[0];
  assign usb_oe       = oe_q;
  assign busy         = (state_q != ST_IDLE);
  assign tx_underflow = unf_q;

endmodule

// File: tb/tb_usb_host_tx.sv
// tb_usb_host_tx: directed packets against a symbol-level model
// of SYNC, stuffing, NRZI and EOP, checked every cycle.
module tb_usb_host_tx;

  localparam int D = 4;
  localparam logic [7:0] SYNC = 8'h80;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       dp, dn, oe, busy, unf;

  always #5 clk = ~clk;

  usb_host_tx #(.CLK_DIV(D), .SYNC_BYTE(SYNC)) dut (
    .clk48_host   (clk),
    .reset        (reset),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .usb_d_p_o    (dp),
    .usb_d_n_o    (dn),
    .usb_oe       (oe),
    .busy         (busy),
    .tx_underflow (unf)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_s(input string nm, input string act, input string exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s", nm, act, exp);
    end
  endtask

  // per-cycle expectations, set by the stimulus process
  bit         e_chk = 0;
  logic [1:0] e_line;
  logic       e_oe, e_busy, e_rdy, e_unf;

  always @(negedge clk) begin
    if (e_chk) begin
      chk("line", {dp, dn}, e_line);
      chk("oe", oe, e_oe);
      chk("busy", busy, e_busy);
      chk("ready", tx_ready, e_rdy);
      chk("underflow", unf, e_unf);
    end
  end

  int oe_run = 0;
  int oe_len = 0;

  always @(negedge clk) begin
    if (oe === 1'b1) oe_run++;
    else begin
      if (oe_run != 0) oe_len = oe_run;
      oe_run = 0;
    end
  end

  // packet description and model output
  logic [7:0] pb[8];
  int         pn;
  bit         pabort;
  logic [1:0] lines[$];
  int         rdy_r[$];
  int         unf_r;
  int         nstuff;
  bit         tail_v;
  logic [7:0] tail_d;
  bit         tail_l;

  function automatic void build();
    bit raw[$];
    bit sb[$];
    int first[$];
    int ones = 0;
    bit lvl = 1'b1;
    logic [7:0] sy = SYNC;
    lines.delete();
    rdy_r.delete();
    unf_r  = -1;
    nstuff = 0;
    for (int k = 0; k < 8; k++) raw.push_back(sy[k]);
    for (int b = 0; b < pn; b++)
      for (int k = 0; k < 8; k++) raw.push_back(pb[b][k]);
    for (int j = 0; j < raw.size(); j++) begin
      if (ones == 6) begin
        sb.push_back(1'b0);
        ones = 0;
        nstuff++;
      end
      if (j >= 8 && (j % 8) == 0) first.push_back(sb.size());
      sb.push_back(raw[j]);
      ones = raw[j] ? ones + 1 : 0;
    end
    if (ones == 6) begin
      sb.push_back(1'b0);
      nstuff++;
    end
    foreach (sb[i]) begin
      if (!sb[i]) lvl = ~lvl;
      lines.push_back(lvl ? 2'b10 : 2'b01);
    end
    lines.push_back(2'b00);
    lines.push_back(2'b00);
    lines.push_back(2'b10);
    for (int b = 1; b < pn; b++) rdy_r.push_back(first[b] * D);
    if (pabort) begin
      rdy_r.push_back(sb.size() * D);
      unf_r = sb.size() * D + 1;
    end
  endfunction

  function automatic string line_str();
    string s = "";
    string c;
    foreach (lines[i]) begin
      if (lines[i] == 2'b10) c = "J";
      else if (lines[i] == 2'b01) c = "K";
      else c = "0";
      s = $sformatf("%s%s", s, c);
    end
    return s;
  endfunction

  task automatic set_idle();
    e_line = 2'b10;
    e_oe   = 1'b0;
    e_busy = 1'b0;
    e_rdy  = 1'b1;
    e_unf  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      set_idle();
      e_chk = 1'b1;
    end
  endtask

  // r = 0 is the handshake cycle; stop < 0 runs to the last busy cycle
  task automatic run_packet(input int stop);
    int nb = 0;
    int last_r = lines.size() * D;
    if (stop >= 0 && stop < last_r) last_r = stop;
    for (int r = 0; r <= last_r; r++) begin
      @(posedge clk);
      #1;
      if (nb < pn) begin
        tx_valid = 1'b1;
        tx_data  = pb[nb];
        tx_last  = (nb == pn - 1) && !pabort;
      end else begin
        tx_valid = tail_v;
        tx_data  = tail_d;
        tx_last  = tail_l;
      end
      if (r == 0) set_idle();
      else begin
        e_line = lines[(r - 1) / D];
        e_oe   = 1'b1;
        e_busy = 1'b1;
        e_rdy  = 1'b0;
        foreach (rdy_r[i]) if (rdy_r[i] == r) e_rdy = 1'b1;
        e_unf  = (r == unf_r);
      end
      e_chk = 1'b1;
      if (nb < pn && r == (nb == 0 ? 0 : rdy_r[nb - 1])) nb++;
    end
  endtask

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_last  = 1'b0;
    tail_v   = 1'b0;
    tail_d   = '0;
    tail_l   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_line", {dp, dn}, 2'b10);
    chk("rst_oe", oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", tx_ready, 1'b0);
    chk("rst_unf", unf, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_idle();
    e_chk = 1'b1;
    idle(3);

    pb[0] = 8'hD2; pn = 1; pabort = 0;
    build();
    chk_s("ack_model", line_str(), "KJKJKJKKJJKJJKKK00J");
    run_packet(-1);
    idle(4);
    chk("ack_oe_len", oe_len, 76);

    pb[0] = 8'hFF; pb[1] = 8'hFF; pn = 2; pabort = 0;
    build();
    chk("ff_nstuff", nstuff, 2);
    chk("ff_nsym", lines.size(), 29);
    chk("ff_ready_delay", rdy_r[0], 68);
    run_packet(-1);
    idle(4);
    chk("ff_oe_len", oe_len, 116);

    pb[0] = 8'h7E; pb[1] = 8'h3F; pn = 2; pabort = 0;
    build();
    run_packet(-1);
    idle(4);
    chk("7e3f_oe_len", oe_len, 116);

    pb[0] = 8'h7E; pb[1] = 8'hFC; pn = 2; pabort = 0;
    build();
    chk("tail_stuff_toggle",
        lines[lines.size() - 4] != lines[lines.size() - 5], 1'b1);
    run_packet(-1);
    idle(4);
    chk("7efc_oe_len", oe_len, 116);

    pb[0] = 8'hA5; pn = 1; pabort = 1;
    build();
    chk("unf_cycle", unf_r, 65);
    run_packet(-1);
    idle(4);
    chk("unf_oe_len", oe_len, 76);

    pb[0] = 8'hFF; pb[1] = 8'h00; pn = 2; pabort = 0;
    build();
    run_packet(50);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    tx_valid = 1'b0;
    e_chk    = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", tx_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_idle();
    e_chk = 1'b1;
    idle(3);
    pb[0] = 8'hD2; pn = 1; pabort = 0;
    build();
    run_packet(-1);
    idle(4);
    chk("post_rst_oe_len", oe_len, 76);

    pb[0] = 8'hC3; pn = 1; pabort = 0;
    tail_v = 1'b1; tail_d = 8'hD2; tail_l = 1'b1;
    build();
    run_packet(-1);
    pb[0] = 8'hD2;
    tail_v = 1'b0;
    build();
    run_packet(-1);
    idle(4);
    chk("b2b_oe_len", oe_len, 76);

    e_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
